// File: rtl/qei_pkg.sv
// qei_pkg: shared count-mode, direction and quadrature transition decode for the QEI decoder
package qei_pkg;
  typedef enum logic [1:0] {MODE_X1 = 2'd0, MODE_X2 = 2'd1, MODE_X4 = 2'd2, MODE_RSVD = 2'd3} mode_e;
  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;
  typedef struct packed {logic step; logic fwd; logic bad;} trans_t;
  function automatic logic [1:0] qei_phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction
  function automatic trans_t qei_decode(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    d = qei_phase(cur) - qei_phase(prev);
    return '{step: d[0], fwd: d == 2'd1 ? DIR_FWD : DIR_REV, bad: d == 2'd2};
  endfunction
endpackage

// File: rtl/qei_channel.sv
// qei_channel: one encoder channel -- sync, debounce, decode, position and windowed velocity
module qei_channel
  import qei_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  mode_e            mode,
  input  logic             pos_clr,
  input  logic             err_clr,
  input  logic             tick,
  output logic [CNT_W-1:0] position,
  output logic [CNT_W-1:0] velocity,
  output logic             dir,
  output logic             err
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] MIN = {1'b1, {(CNT_W-1){1'b0}}};
  logic [1:0] s1, s2, filt, prev;
  logic [1:0][4:0] cnt;
  logic [CNT_W-1:0] acc, step_val;
  trans_t t;
  logic ev, acc_sat;
  // two-flop synchroniser for the asynchronous {A,B} pair
  always_ff @(posedge clk) begin
    s1 <= {a, b};
    s2 <= s1;
  end
  // per-bit debounce: accept a new level after FILT_LEN equal samples; reset adopts the live level
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      cnt[i]  <= (rst || s2[i] == filt[i] || cnt[i] == 5'(FILT_LEN - 1)) ? 5'd0 : cnt[i] + 5'd1;
      filt[i] <= (rst || cnt[i] == 5'(FILT_LEN - 1)) ? s2[i] : filt[i];
    end
  // classify the filtered transition and decide whether the current mode counts it
  always_comb begin
    t        = qei_decode(prev, filt);
    ev       = t.step && (mode == MODE_X1 ? filt[1] && !prev[1] : mode == MODE_X2 ? filt[1] != prev[1] : 1'b1);
    step_val = t.fwd ? ONE : '1;
    acc_sat  = ev && (t.fwd ? acc == MAX : acc == MIN);
  end
  // position wraps, accumulator saturates and restarts on the window tick, err is sticky
  always_ff @(posedge clk)
    if (rst) begin
      prev     <= s2;
      position <= '0;
      acc      <= '0;
      velocity <= '0;
      dir      <= DIR_REV;
      err      <= 1'b0;
    end else begin
      prev     <= filt;
      position <= pos_clr ? '0 : ev ? position + step_val : position;
      acc      <= tick ? (ev ? step_val : '0) : (ev && !acc_sat) ? acc + step_val : acc;
      velocity <= tick ? acc : velocity;
      dir      <= ev ? t.fwd : dir;
      err      <= t.bad || (err && !err_clr);
    end
endmodule

// File: rtl/qei_multi_decoder.sv
// qei_multi_decoder: N_CH quadrature decoders sharing one velocity window timer
module qei_multi_decoder
  import qei_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int FILT_LEN   = 4,
  parameter int WINDOW_CYC = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            ch_a,
  input  logic [N_CH-1:0]            ch_b,
  input  logic [1:0]                 mode,
  input  logic [N_CH-1:0]            pos_clr,
  input  logic [N_CH-1:0]            err_clr,
  output logic [N_CH-1:0][CNT_W-1:0] position,
  output logic [N_CH-1:0][CNT_W-1:0] velocity,
  output logic                       vel_valid,
  output logic [N_CH-1:0]            dir,
  output logic [N_CH-1:0]            err
);
  localparam int TW = $clog2(WINDOW_CYC);
  logic [TW-1:0] timer;
  logic tick;
  assign tick = timer == TW'(WINDOW_CYC - 1);
  // shared window timer; vel_valid marks the cycle after the velocity latch
  always_ff @(posedge clk) begin
    timer     <= (rst || tick) ? '0 : timer + TW'(1);
    vel_valid <= !rst && tick;
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    qei_channel #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .a        (ch_a[c]),
      .b        (ch_b[c]),
      .mode     (mode_e'(mode)),
      .pos_clr  (pos_clr[c]),
      .err_clr  (err_clr[c]),
      .tick     (tick),
      .position (position[c]),
      .velocity (velocity[c]),
      .dir      (dir[c]),
      .err      (err[c])
    );
  end
endmodule

// File: tb/tb_qei_multi_decoder.sv
// tb_qei_multi_decoder: vector table plus hand sequences for latency, glitch, error, wrap and velocity
module tb_qei_multi_decoder;
  localparam int N_CH = 4, CNT_W = 8, FILT_LEN = 4, WINDOW_CYC = 1000;
  typedef struct {logic [1:0] mode; logic [1:0] ab; int pos; logic dir; logic err;} vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [N_CH-1:0] ch_a = '0, ch_b = '0, pos_clr = '0, err_clr = '0;
  logic [1:0] mode = 2'd2;
  logic [N_CH-1:0][CNT_W-1:0] position, velocity;
  logic vel_valid;
  logic [N_CH-1:0] dir, err;
  int n_vec = 0, n_bad = 0;
  int vq[$];
  vec_t sbq[$];
  vec_t tbl[28];
  logic [1:0] fwd[4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  qei_multi_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .WINDOW_CYC(WINDOW_CYC)) dut (
    .clk(clk), .rst(rst), .ch_a(ch_a), .ch_b(ch_b), .mode(mode), .pos_clr(pos_clr), .err_clr(err_clr),
    .position(position), .velocity(velocity), .vel_valid(vel_valid), .dir(dir), .err(err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int c, input logic [1:0] ab);
    @(posedge clk);
    #1;
    ch_a[c] = ab[1];
    ch_b[c] = ab[0];
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_vv();
    int k = 0;
    logic got = 1'b0;
    while (k < 1200 && !got) begin
      @(negedge clk);
      got = vel_valid;
      k++;
    end
    check("vel_valid_seen", 32'(got), 1);
  endtask

  always @(negedge clk)
    if (vel_valid && vq.size() > 0) check("velocity3", $signed(velocity[3]), vq.pop_front());

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    vec_t e;
    tbl = '{
      '{2'd2, 2'b10, 1, 1'b1, 1'b0}, '{2'd2, 2'b11, 2, 1'b1, 1'b0}, '{2'd2, 2'b01, 3, 1'b1, 1'b0}, '{2'd2, 2'b00, 4, 1'b1, 1'b0},
      '{2'd2, 2'b01, 3, 1'b0, 1'b0}, '{2'd2, 2'b11, 2, 1'b0, 1'b0}, '{2'd2, 2'b10, 1, 1'b0, 1'b0}, '{2'd2, 2'b00, 0, 1'b0, 1'b0},
      '{2'd1, 2'b10, 1, 1'b1, 1'b0}, '{2'd1, 2'b11, 1, 1'b1, 1'b0}, '{2'd1, 2'b01, 2, 1'b1, 1'b0}, '{2'd1, 2'b00, 2, 1'b1, 1'b0},
      '{2'd1, 2'b01, 2, 1'b1, 1'b0}, '{2'd1, 2'b11, 1, 1'b0, 1'b0}, '{2'd1, 2'b10, 1, 1'b0, 1'b0}, '{2'd1, 2'b00, 0, 1'b0, 1'b0},
      '{2'd0, 2'b10, 1, 1'b1, 1'b0}, '{2'd0, 2'b11, 1, 1'b1, 1'b0}, '{2'd0, 2'b01, 1, 1'b1, 1'b0}, '{2'd0, 2'b00, 1, 1'b1, 1'b0},
      '{2'd0, 2'b01, 1, 1'b1, 1'b0}, '{2'd0, 2'b11, 0, 1'b0, 1'b0}, '{2'd0, 2'b10, 0, 1'b0, 1'b0}, '{2'd0, 2'b00, 0, 1'b0, 1'b0},
      '{2'd3, 2'b10, 1, 1'b1, 1'b0}, '{2'd3, 2'b00, 0, 1'b0, 1'b0},
      '{2'd2, 2'b11, 0, 1'b0, 1'b1}, '{2'd2, 2'b00, 0, 1'b0, 1'b1}};
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_position", 32'(position), 0);
    check("rst_velocity", 32'(velocity), 0);
    check("rst_vel_valid", 32'(vel_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_dir", 32'(dir), 0);
    drive(0, fwd[0]);
    lat = 0;
    while (lat < 20 && position[0] != 8'd1) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("x4_latency", lat, FILT_LEN + 3);
    for (int i = 1; i < 8; i++) begin
      drive(0, fwd[i % 4]);
      settle();
    end
    check("x4_fwd_pos", $signed(position[0]), 8);
    check("x4_fwd_dir", 32'(dir[0]), 1);
    @(posedge clk);
    #1 ch_a[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 ch_a[0] = 1'b0;
    settle();
    check("glitch_pos", $signed(position[0]), 8);
    drive(0, 2'b11);
    settle();
    check("illegal_err", 32'(err[0]), 1);
    check("illegal_pos", $signed(position[0]), 8);
    check("illegal_dir", 32'(dir[0]), 1);
    @(posedge clk);
    #1 err_clr[0] = 1'b1;
    @(posedge clk);
    #1 err_clr[0] = 1'b0;
    @(negedge clk);
    check("err_clr", 32'(err[0]), 0);
    drive(0, 2'b00);
    repeat (6) @(posedge clk);
    #1 err_clr[0] = 1'b1;
    @(posedge clk);
    #1 err_clr[0] = 1'b0;
    @(negedge clk);
    check("err_over_clr", 32'(err[0]), 1);
    for (int i = 0; i < 28; i++) begin
      mode = tbl[i].mode;
      drive(1, tbl[i].ab);
      sbq.push_back(tbl[i]);
      settle();
      e = sbq.pop_front();
      check($sformatf("vec%0d_pos", i), $signed(position[1]), e.pos);
      check($sformatf("vec%0d_dir", i), 32'(dir[1]), 32'(e.dir));
      check($sformatf("vec%0d_err", i), 32'(err[1]), 32'(e.err));
    end
    mode = 2'd2;
    for (int i = 0; i < 127; i++) begin
      drive(2, fwd[i % 4]);
      repeat (6) @(posedge clk);
    end
    settle();
    check("wrap_127", $signed(position[2]), 127);
    drive(2, fwd[3]);
    settle();
    check("wrap_max_plus1", $signed(position[2]), -128);
    drive(2, 2'b01);
    settle();
    check("wrap_min_minus1", $signed(position[2]), 127);
    drive(2, 2'b00);
    settle();
    check("wrap_again", $signed(position[2]), -128);
    wait_vv();
    for (int i = 0; i < 10; i++) begin
      drive(3, fwd[i % 4]);
      if (i == 0) vq.push_back(10);
      if (i < 9) settle();
    end
    repeat (6) @(posedge clk);
    #1 pos_clr[3] = 1'b1;
    @(posedge clk);
    #1 pos_clr[3] = 1'b0;
    @(negedge clk);
    check("pos_clr_wins", $signed(position[3]), 0);
    wait_vv();
    @(negedge clk);
    check("vel_valid_one_cycle", 32'(vel_valid), 0);
    vq.push_back(0);
    vq.push_back(1);
    repeat (992) @(posedge clk);
    #1;
    ch_a[3] = 1'b0;
    ch_b[3] = 1'b1;
    wait_vv();
    check("terminal_evt_pos", $signed(position[3]), 1);
    wait_vv();
    @(negedge clk);
    check("velocity_windows_seen", vq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
